// File: rtl/matrix_loader.sv
// matrix_loader: collects an m x n matrix one element per handshake and packs it
// row-major into one of two slots of a 400-bit matrix bus, held until consumed.
module matrix_loader #(
  parameter int MAX_DIM = 5,
  parameter int ELEM_W  = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [2:0]                         m_in,
  input  logic [2:0]                         n_in,
  input  logic                               slot_sel,
  input  logic [ELEM_W-1:0]                  elem_in,
  input  logic                               elem_valid,
  output logic                               elem_ready,
  input  logic                               abort,
  input  logic                               consume,
  output logic [2:0]                         m_out,
  output logic [2:0]                         n_out,
  output logic [2*MAX_DIM*MAX_DIM*ELEM_W-1:0] matrices_out,
  output logic                               valid,
  output logic                               busy,
  output logic                               error
);
  localparam int SLOT_W = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int IDX_W  = $clog2(2 * SLOT_W);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]          r_state;
  logic [2*SLOT_W-1:0] r_mat;
  logic [2:0]          r_m, r_n, r_row, r_col;
  logic                r_slot, r_err;
  logic                w_dims_ok, w_col_last;
  logic [IDX_W-1:0]    w_idx;
  assign w_dims_ok  = (m_in != 3'd0) && (m_in <= 3'(MAX_DIM)) && (n_in != 3'd0) && (n_in <= 3'(MAX_DIM));
  assign w_col_last = r_col == r_n - 3'd1;
  assign w_idx      = IDX_W'((r_slot ? SLOT_W : 0) + (int'(r_row) * MAX_DIM + int'(r_col)) * ELEM_W);
  assign elem_ready   = r_state == S_LOAD;
  assign busy         = r_state == S_LOAD;
  assign valid        = r_state == S_DONE;
  assign error        = r_err;
  assign m_out        = r_m;
  assign n_out        = r_n;
  assign matrices_out = r_mat;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mat   <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_slot  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_dims_ok) begin
            r_m     <= m_in;
            r_n     <= n_in;
            r_slot  <= slot_sel;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= S_LOAD;
            if (slot_sel) r_mat[2*SLOT_W-1:SLOT_W] <= '0;
            else          r_mat[SLOT_W-1:0]        <= '0;
          end else r_err <= 1'b1;
        end
        S_LOAD: if (abort) begin
          // abort wins over a same-cycle transfer
          if (r_slot) r_mat[2*SLOT_W-1:SLOT_W] <= '0;
          else        r_mat[SLOT_W-1:0]        <= '0;
          r_m     <= '0;
          r_n     <= '0;
          r_state <= S_IDLE;
        end else if (elem_valid) begin
          r_mat[w_idx +: ELEM_W] <= elem_in;
          r_col <= w_col_last ? 3'd0 : r_col + 3'd1;
          r_row <= w_col_last ? r_row + 3'd1 : r_row;
          if (w_col_last && r_row == r_m - 3'd1) r_state <= S_DONE;
        end
        S_DONE: if (consume) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
